// File: rtl/picomips_pkg.sv
// Shared types and helpers for the multi-cycle picoMIPS core.
package picomips_pkg;

  localparam int OPW = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUB  = 4'h3,
    OP_SUBI = 4'h4,
    OP_MUL  = 4'h5,
    OP_MULI = 4'h6,
    OP_IN   = 4'h7,
    OP_OUT  = 4'h8,
    OP_BEQ  = 4'h9,
    OP_BNE  = 4'hA,
    OP_JMP  = 4'hB,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_EXEC = 2'd0,
    ST_MUL  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Instruction width is always derived from the datapath and register-address widths.
  function automatic int isize(input int n, input int raddr);
    return OPW + 3 * raddr + n;
  endfunction

endpackage

// File: rtl/picomips_core_mc_if.sv
// Program-ROM fetch port plus the valid/ready input and output channels of the core.
interface picomips_core_mc_if #(
  parameter int N     = 8,
  parameter int RADDR = 4,
  parameter int PSIZE = 6
);
  localparam int ISIZE = picomips_pkg::isize(N, RADDR);

  logic [PSIZE-1:0] imem_addr;
  logic [ISIZE-1:0] imem_data;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             halted;

  // Core side.
  modport master (
    output imem_addr, in_ready, out_data, out_valid, halted,
    input  imem_data, in_data, in_valid, out_ready
  );

  // Board wrapper / ROM side.
  modport slave (
    input  imem_addr, in_ready, out_data, out_valid, halted,
    output imem_data, in_data, in_valid, out_ready
  );
endinterface

// File: rtl/picomips_mul_seq.sv
// Sequential signed fractional (Q1.(N-1)) multiplier: N shift-add steps on
// magnitudes, sign applied to the final sum, (-1)*(-1) saturated to the largest
// positive value. done and result are valid in the last busy cycle so the caller
// can write back on that same edge.
module picomips_mul_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int              CW      = $clog2(N);
  localparam logic [CW-1:0]   LAST    = CW'(N - 1);
  localparam logic [2*N-1:0]  SAT_MAG = {2'b01, {(2*N-2){1'b0}}};
  localparam logic [N-1:0]    POS_MAX = {1'b0, {(N-1){1'b1}}};

  logic [2*N-1:0] acc_r, mcand_r, acc_nx_s, prod_s;
  logic [N-1:0]   mplier_r;
  logic [CW-1:0]  cnt_r;
  logic           busy_r, neg_r;
  logic           unused_s;

  // Magnitude of a two's-complement value; the most negative input maps to 2**(N-1).
  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    if (v[N-1]) begin
      return ~v + {{(N-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Operand capture on start, then one shift-add step per busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*N){1'b0}};
      mcand_r  <= {(2*N){1'b0}};
      mplier_r <= {N{1'b0}};
      neg_r    <= 1'b0;
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*N){1'b0}};
      mcand_r  <= {{N{1'b0}}, mag(a)};
      mplier_r <= mag(b);
      neg_r    <= a[N-1] ^ b[N-1];
    end else if (busy_r) begin
      acc_r    <= acc_nx_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      if (cnt_r == LAST) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Next partial sum, signed product and Q1.(N-1) extraction with saturation.
  always_comb begin
    acc_nx_s = acc_r;
    prod_s   = {(2*N){1'b0}};
    result   = {N{1'b0}};
    if (mplier_r[0]) begin
      acc_nx_s = acc_r + mcand_r;
    end else begin
      acc_nx_s = acc_r;
    end
    if (neg_r) begin
      prod_s = {(2*N){1'b0}} - acc_nx_s;
    end else begin
      prod_s = acc_nx_s;
    end
    if (!neg_r && (acc_nx_s == SAT_MAG)) begin
      result = POS_MAX;
    end else begin
      result = prod_s[2*N-2 -: N];
    end
  end

  assign done     = busy_r && (cnt_r == LAST);
  assign unused_s = ^{prod_s[2*N-1], prod_s[N-2:0]};

endmodule

// File: rtl/picomips_core_mc.sv
// Multi-cycle picoMIPS core: register file, PC, decode, IN/OUT handshakes and
// the EXEC/MUL/HALT sequencer. Branch targets come from the low PSIZE bits of
// the immediate, so PSIZE must not exceed N.
module picomips_core_mc
  import picomips_pkg::*;
#(
  parameter int N     = 8,
  parameter int RADDR = 4,
  parameter int PSIZE = 6
) (
  input logic               clk,
  input logic               rst,
  picomips_core_mc_if.master bus
);
  localparam int ISIZE = isize(N, RADDR);
  localparam int NREG  = 2 ** RADDR;

  state_t           state_r, state_nx_s;
  logic [PSIZE-1:0] pc_r, pc_nx_s, pc_inc_s, target_s;
  logic [N-1:0]     regs_r [NREG];
  logic [RADDR-1:0] mul_rd_r;
  logic [N-1:0]     out_data_r;
  logic             out_valid_r;

  logic [ISIZE-1:0] instr_s;
  opcode_t          op_s;
  logic [RADDR-1:0] rd_s, rs_s, rt_s;
  logic [N-1:0]     imm_s, rd_val_s, rs_val_s, rt_val_s;

  logic             we_s;
  logic [RADDR-1:0] wa_s;
  logic [N-1:0]     wd_s;
  logic             mul_start_s, mul_done_s;
  logic [N-1:0]     mul_b_s, mul_res_s;
  logic             out_free_s, out_load_s, in_ready_s;

  // Instruction fields.
  assign instr_s  = bus.imem_data;
  assign op_s     = opcode_t'(instr_s[ISIZE-1 -: OPW]);
  assign rd_s     = instr_s[ISIZE-1-OPW -: RADDR];
  assign rs_s     = instr_s[ISIZE-1-OPW-RADDR -: RADDR];
  assign rt_s     = instr_s[ISIZE-1-OPW-2*RADDR -: RADDR];
  assign imm_s    = instr_s[N-1:0];
  assign target_s = imm_s[PSIZE-1:0];
  assign pc_inc_s = pc_r + {{(PSIZE-1){1'b0}}, 1'b1};

  // R0 is never written, so a plain read already returns zero for it.
  assign rd_val_s = regs_r[rd_s];
  assign rs_val_s = regs_r[rs_s];
  assign rt_val_s = regs_r[rt_s];

  // The output slot can take a new value when empty or being drained this cycle.
  assign out_free_s = !out_valid_r || bus.out_ready;

  picomips_mul_seq #(.N(N)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start_s),
    .a      (rs_val_s),
    .b      (mul_b_s),
    .done   (mul_done_s),
    .result (mul_res_s)
  );

  // Sequencer: next state, next PC, write-back and handshake strobes.
  always_comb begin
    state_nx_s  = state_r;
    pc_nx_s     = pc_r;
    we_s        = 1'b0;
    wa_s        = rd_s;
    wd_s        = {N{1'b0}};
    mul_start_s = 1'b0;
    mul_b_s     = imm_s;
    out_load_s  = 1'b0;
    in_ready_s  = 1'b0;
    case (state_r)
      ST_EXEC: begin
        case (op_s)
          OP_ADD: begin
            we_s = 1'b1; wd_s = rs_val_s + rt_val_s; pc_nx_s = pc_inc_s;
          end
          OP_ADDI: begin
            we_s = 1'b1; wd_s = rs_val_s + imm_s; pc_nx_s = pc_inc_s;
          end
          OP_SUB: begin
            we_s = 1'b1; wd_s = rs_val_s - rt_val_s; pc_nx_s = pc_inc_s;
          end
          OP_SUBI: begin
            we_s = 1'b1; wd_s = rs_val_s - imm_s; pc_nx_s = pc_inc_s;
          end
          OP_MUL: begin
            mul_start_s = 1'b1; mul_b_s = rt_val_s; state_nx_s = ST_MUL;
          end
          OP_MULI: begin
            mul_start_s = 1'b1; mul_b_s = imm_s; state_nx_s = ST_MUL;
          end
          OP_IN: begin
            in_ready_s = !rst;
            if (bus.in_valid && !rst) begin
              we_s = 1'b1; wd_s = bus.in_data; pc_nx_s = pc_inc_s;
            end else begin
              pc_nx_s = pc_r;
            end
          end
          OP_OUT: begin
            if (out_free_s) begin
              out_load_s = 1'b1; pc_nx_s = pc_inc_s;
            end else begin
              pc_nx_s = pc_r;
            end
          end
          OP_BEQ: begin
            if (rd_val_s == rs_val_s) begin
              pc_nx_s = target_s;
            end else begin
              pc_nx_s = pc_inc_s;
            end
          end
          OP_BNE: begin
            if (rd_val_s != rs_val_s) begin
              pc_nx_s = target_s;
            end else begin
              pc_nx_s = pc_inc_s;
            end
          end
          OP_JMP:  pc_nx_s = target_s;
          OP_HALT: state_nx_s = ST_HALT;
          default: pc_nx_s = pc_inc_s;
        endcase
      end
      ST_MUL: begin
        if (mul_done_s) begin
          we_s       = 1'b1;
          wa_s       = mul_rd_r;
          wd_s       = mul_res_s;
          pc_nx_s    = pc_inc_s;
          state_nx_s = ST_EXEC;
        end else begin
          state_nx_s = ST_MUL;
        end
      end
      ST_HALT: state_nx_s = ST_HALT;
      default: state_nx_s = ST_EXEC;
    endcase
  end

  // State and program counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EXEC;
      pc_r    <= {PSIZE{1'b0}};
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
    end
  end

  // Register file write-back; writes to R0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {N{1'b0}};
      end
    end else if (we_s && (wa_s != {RADDR{1'b0}})) begin
      regs_r[wa_s] <= wd_s;
    end
  end

  // Destination register of the multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_rd_r <= {RADDR{1'b0}};
    end else if (mul_start_s) begin
      mul_rd_r <= rd_s;
    end
  end

  // Output buffer: load on OUT, drain on out_ready, both together keeps it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {N{1'b0}};
      out_valid_r <= 1'b0;
    end else if (out_load_s) begin
      out_data_r  <= rs_val_s;
      out_valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.imem_addr = pc_r;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.halted    = (state_r == ST_HALT);

endmodule

// File: tb/tb_picomips_core_mc.sv
// Directed bench for picomips_core_mc (N=8, RADDR=4, PSIZE=6) with a ROM model.
module tb_picomips_core_mc;
  import picomips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] rom [64];
  int tests_run = 0;
  int tests_failed = 0;

  picomips_core_mc_if #(.N(8), .RADDR(4), .PSIZE(6)) bus ();

  picomips_core_mc #(.N(8), .RADDR(4), .PSIZE(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.imem_data = rom[bus.imem_addr];

  always #5 clk = ~clk;

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [7:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_prog();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 24'h000000;
  endtask

  task automatic release_rst();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_out(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    begin_prog();
    rom[0] = enc(OP_IN, 4'd1, 4'd0, 4'd0, 8'h00);
    step(); step();
    tests_run++; if (bus.imem_addr !== 6'd0) begin tests_failed++; $display("FAIL reset_pc got %0d exp 0", bus.imem_addr); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    tests_run++; if (bus.out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
    tests_run++; if (bus.halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready_after got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_arith();
    begin_prog();
    rom[0]  = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 8'h05);
    rom[1]  = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 8'hFD);
    rom[2]  = enc(OP_ADD,  4'd3, 4'd1, 4'd2, 8'h00);
    rom[3]  = enc(OP_OUT,  4'd0, 4'd3, 4'd0, 8'h00);
    rom[4]  = enc(OP_SUB,  4'd4, 4'd1, 4'd2, 8'h00);
    rom[5]  = enc(OP_OUT,  4'd0, 4'd4, 4'd0, 8'h00);
    rom[6]  = enc(OP_SUBI, 4'd5, 4'd0, 4'd0, 8'h01);
    rom[7]  = enc(OP_OUT,  4'd0, 4'd5, 4'd0, 8'h00);
    rom[8]  = enc(OP_ADDI, 4'd0, 4'd0, 4'd0, 8'h07);
    rom[9]  = enc(OP_OUT,  4'd0, 4'd0, 4'd0, 8'h00);
    rom[10] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'h00);
    bus.out_ready = 1'b1;
    release_rst();
    step(); step(); step(); step();
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL arith_valid_c4 got %b exp 1", bus.out_valid); end
    tests_run++; if (bus.out_data !== 8'h02) begin tests_failed++; $display("FAIL arith_add got %h exp 02", bus.out_data); end
    tests_run++; if (bus.imem_addr !== 6'd4) begin tests_failed++; $display("FAIL arith_pc_c4 got %0d exp 4", bus.imem_addr); end
    step();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL arith_drain got %b exp 0", bus.out_valid); end
    step();
    tests_run++; if (bus.out_data !== 8'h08) begin tests_failed++; $display("FAIL arith_sub got %h exp 08", bus.out_data); end
    step(); step();
    tests_run++; if (bus.out_data !== 8'hFF) begin tests_failed++; $display("FAIL arith_subi_wrap got %h exp ff", bus.out_data); end
    step(); step();
    tests_run++; if (bus.out_data !== 8'h00) begin tests_failed++; $display("FAIL arith_r0 got %h exp 00", bus.out_data); end
    step();
    tests_run++; if (bus.halted !== 1'b1) begin tests_failed++; $display("FAIL arith_halted got %b exp 1", bus.halted); end
    step(); step(); step();
    tests_run++; if (bus.imem_addr !== 6'd10) begin tests_failed++; $display("FAIL arith_halt_pc got %0d exp 10", bus.imem_addr); end
    tests_run++; if (bus.halted !== 1'b1) begin tests_failed++; $display("FAIL arith_halt_sticky got %b exp 1", bus.halted); end
  endtask

  task automatic test_in();
    begin_prog();
    rom[0] = enc(OP_IN,   4'd1, 4'd0, 4'd0, 8'h00);
    rom[1] = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 8'h00);
    rom[2] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'h00);
    release_rst();
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++; if (bus.imem_addr !== 6'd0) begin tests_failed++; $display("FAIL in_stall_pc[%0d] got %0d exp 0", i, bus.imem_addr); end
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL in_stall_ready[%0d] got %b exp 1", i, bus.in_ready); end
    end
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    step();
    bus.in_valid = 1'b0;
    tests_run++; if (bus.imem_addr !== 6'd1) begin tests_failed++; $display("FAIL in_accept_pc got %0d exp 1", bus.imem_addr); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL in_ready_drop got %b exp 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    tests_run++; if (bus.out_data !== 8'h5A) begin tests_failed++; $display("FAIL in_value got %h exp 5a", bus.out_data); end
  endtask

  task automatic test_mul();
    bit ok;
    begin_prog();
    rom[0]  = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 8'h40);
    rom[1]  = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 8'h00);
    rom[2]  = enc(OP_MULI, 4'd1, 4'd1, 4'd0, 8'h40);
    rom[3]  = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 8'h00);
    rom[4]  = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 8'h80);
    rom[5]  = enc(OP_MUL,  4'd3, 4'd2, 4'd2, 8'h00);
    rom[6]  = enc(OP_OUT,  4'd0, 4'd3, 4'd0, 8'h00);
    rom[7]  = enc(OP_ADDI, 4'd4, 4'd0, 4'd0, 8'hC0);
    rom[8]  = enc(OP_MULI, 4'd5, 4'd4, 4'd0, 8'h40);
    rom[9]  = enc(OP_OUT,  4'd0, 4'd5, 4'd0, 8'h00);
    rom[10] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'h00);
    release_rst();
    step(); step();
    tests_run++; if (bus.out_data !== 8'h40) begin tests_failed++; $display("FAIL mul_pre_out got %h exp 40", bus.out_data); end
    step();
    tests_run++; if (bus.imem_addr !== 6'd2) begin tests_failed++; $display("FAIL mul_start_pc got %0d exp 2", bus.imem_addr); end
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) bus.out_ready = 1'b1;
      tests_run++; if (bus.imem_addr !== 6'd2) begin tests_failed++; $display("FAIL mul_busy_pc[%0d] got %0d exp 2", i, bus.imem_addr); end
      if (i == 1) begin
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL mul_out_drain got %b exp 0", bus.out_valid); end
      end
    end
    step();
    tests_run++; if (bus.imem_addr !== 6'd3) begin tests_failed++; $display("FAIL mul_done_pc got %0d exp 3", bus.imem_addr); end
    step();
    tests_run++; if (bus.out_data !== 8'h20) begin tests_failed++; $display("FAIL mul_half_half got %h exp 20", bus.out_data); end
    wait_out(40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL mul_sat_timeout got 0 exp 1"); end
    tests_run++; if (bus.out_data !== 8'h7F) begin tests_failed++; $display("FAIL mul_sat got %h exp 7f", bus.out_data); end
    wait_out(40, ok);
    tests_run++; if (bus.out_data !== 8'hE0) begin tests_failed++; $display("FAIL mul_neg got %h exp e0", bus.out_data); end
    step();
    tests_run++; if (bus.halted !== 1'b1) begin tests_failed++; $display("FAIL mul_halted got %b exp 1", bus.halted); end
  endtask

  task automatic test_back_to_back();
    begin_prog();
    rom[0] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 8'h11);
    rom[1] = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 8'h22);
    rom[2] = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 8'h00);
    rom[3] = enc(OP_OUT,  4'd0, 4'd2, 4'd0, 8'h00);
    rom[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'h00);
    release_rst();
    step(); step(); step();
    tests_run++; if (bus.out_data !== 8'h11) begin tests_failed++; $display("FAIL b2b_first got %h exp 11", bus.out_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (bus.imem_addr !== 6'd3) begin tests_failed++; $display("FAIL b2b_stall_pc[%0d] got %0d exp 3", i, bus.imem_addr); end
      tests_run++; if (bus.out_data !== 8'h11) begin tests_failed++; $display("FAIL b2b_hold[%0d] got %h exp 11", i, bus.out_data); end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    tests_run++; if (bus.out_data !== 8'h22) begin tests_failed++; $display("FAIL b2b_second got %h exp 22", bus.out_data); end
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_no_bubble got %b exp 1", bus.out_valid); end
    step();
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_halt_hold got %b exp 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    step();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_halt_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_branch();
    bit ok;
    begin_prog();
    rom[0]  = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 8'd3);
    rom[1]  = enc(OP_ADDI, 4'd2, 4'd2, 4'd0, 8'd1);
    rom[2]  = enc(OP_SUBI, 4'd1, 4'd1, 4'd0, 8'd1);
    rom[3]  = enc(OP_BNE,  4'd1, 4'd0, 4'd0, 8'd1);
    rom[4]  = enc(OP_OUT,  4'd0, 4'd2, 4'd0, 8'd0);
    rom[5]  = enc(OP_BEQ,  4'd1, 4'd2, 4'd0, 8'd0);
    rom[6]  = enc(OP_BEQ,  4'd0, 4'd1, 4'd0, 8'd9);
    rom[7]  = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'd0);
    rom[8]  = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'd0);
    rom[9]  = enc(OP_JMP,  4'd0, 4'd0, 4'd0, 8'd63);
    rom[63] = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 8'd0);
    bus.out_ready = 1'b1;
    release_rst();
    wait_out(30, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL br_timeout got 0 exp 1"); end
    tests_run++; if (bus.out_data !== 8'h03) begin tests_failed++; $display("FAIL br_loop_count got %h exp 03", bus.out_data); end
    tests_run++; if (bus.imem_addr !== 6'd5) begin tests_failed++; $display("FAIL br_exit_pc got %0d exp 5", bus.imem_addr); end
    step();
    tests_run++; if (bus.imem_addr !== 6'd6) begin tests_failed++; $display("FAIL br_beq_nt got %0d exp 6", bus.imem_addr); end
    step();
    tests_run++; if (bus.imem_addr !== 6'd9) begin tests_failed++; $display("FAIL br_beq_t got %0d exp 9", bus.imem_addr); end
    step();
    tests_run++; if (bus.imem_addr !== 6'd63) begin tests_failed++; $display("FAIL br_jmp got %0d exp 63", bus.imem_addr); end
    step();
    tests_run++; if (bus.imem_addr !== 6'd0) begin tests_failed++; $display("FAIL br_wrap got %0d exp 0", bus.imem_addr); end
    tests_run++; if (bus.out_data !== 8'h00) begin tests_failed++; $display("FAIL br_out63 got %h exp 00", bus.out_data); end
  endtask

  task automatic test_reset_mid();
    begin_prog();
    rom[0] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'h00);
    release_rst();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++; if (bus.halted !== 1'b1) begin tests_failed++; $display("FAIL rm_halt_sticky[%0d] got %b exp 1", i, bus.halted); end
    end
    begin_prog();
    rom[0] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 8'h40);
    rom[1] = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 8'h00);
    rom[2] = enc(OP_MULI, 4'd1, 4'd1, 4'd0, 8'h40);
    rom[3] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'h00);
    release_rst();
    tests_run++; if (bus.halted !== 1'b0) begin tests_failed++; $display("FAIL rm_halt_cleared got %b exp 0", bus.halted); end
    step(); step(); step(); step(); step(); step();
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_pending got %b exp 1", bus.out_valid); end
    rst = 1'b1;
    step();
    tests_run++; if (bus.imem_addr !== 6'd0) begin tests_failed++; $display("FAIL rm_pc got %0d exp 0", bus.imem_addr); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_out_valid got %b exp 0", bus.out_valid); end
    tests_run++; if (bus.out_data !== 8'h00) begin tests_failed++; $display("FAIL rm_out_data got %h exp 00", bus.out_data); end
    tests_run++; if (bus.halted !== 1'b0) begin tests_failed++; $display("FAIL rm_halted got %b exp 0", bus.halted); end
    rom[0] = enc(OP_OUT,  4'd0, 4'd1, 4'd0, 8'h00);
    rom[1] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 8'h00);
    release_rst();
    step();
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_out_after got %b exp 1", bus.out_valid); end
    tests_run++; if (bus.out_data !== 8'h00) begin tests_failed++; $display("FAIL rm_reg_cleared got %h exp 00", bus.out_data); end
  endtask

  initial begin
    begin_prog();
    test_reset();
    test_arith();
    test_in();
    test_mul();
    test_back_to_back();
    test_branch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
